animation_ladder_ctl: RTL and testbench

- Sequencer that produces the `animation` and `counter` controls for the ladder-drawing stage.
- Once `start_game` is high, it steps `counter` from 0 to MAX_STEP at a fixed number of frames per step. It then holds the final ladder for a set number of frames and signals completion.
- All updates are aligned to the frame boundary (vsync rising edge), so the ladder stage never sees `counter` change mid-frame.
- Sits between the game top-level control and the ladder-drawing stage, in the same clock domain as the VGA timing chain.

---
 rtl/animation_ladder_ctl.sv | 184 ++++++++++++++++++
 tb/tb_animation_ladder_ctl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/animation_ladder_ctl.sv
// ---------------------------------------------------------------------------
// animation_ladder_ctl
//
// Purpose:
//   Sequences the ladder-drawing animation. After start_game rises, counter
//   steps from 0 up to MAX_STEP, advancing once every FRAMES_PER_STEP frames.
//   The final ladder is then held for HOLD_FRAMES frames before the block
//   reports completion. Every state change is aligned to a frame tick (the
//   rising edge of vsync), so the drawing stage never sees counter move
//   partway through a frame.
//
// Ports:
//   clk         in   pixel clock
//   rst         in   asynchronous, active-high reset
//   start_game  in   level; game running, low forces IDLE
//   vsync       in   vsync from the VGA timing chain
//   skip        in   single-cycle pulse; jump straight to DONE
//   animation   out  registered; high in RUN and HOLD
//   counter     out  registered; current ladder step, 0..MAX_STEP
//   done        out  registered; high in HOLD and DONE
// ---------------------------------------------------------------------------
module animation_ladder_ctl #(
  parameter int FRAMES_PER_STEP = 8,
  parameter int MAX_STEP        = 15,
  parameter int HOLD_FRAMES     = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_game,
  input  logic       vsync,
  input  logic       skip,
  output logic       animation,
  output logic [3:0] counter,
  output logic       done
);

  localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int HC_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(FRAMES_PER_STEP - 1);
  localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(HOLD_FRAMES - 1);
  localparam logic [3:0]      STEP_MAX   = 4'(MAX_STEP);
  localparam logic [3:0]      STEP_LAST  = 4'(MAX_STEP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_vsync_q;
  logic            w_tick;
  logic [FC_W-1:0] r_frame_cnt;
  logic [FC_W-1:0] w_frame_cnt_next;
  logic [HC_W-1:0] r_hold_cnt;
  logic [HC_W-1:0] w_hold_cnt_next;
  logic            r_animation;
  logic            w_animation_next;
  logic [3:0]      r_counter;
  logic [3:0]      w_counter_next;
  logic            r_done;
  logic            w_done_next;

  // Frame tick: first cycle vsync is seen high. A long vsync high produces
  // a single tick, and a vsync that is already high when RUN starts is not
  // counted until it falls and rises again.
  assign w_tick = vsync & ~r_vsync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_vsync_q   <= 1'b0;
      r_frame_cnt <= '0;
      r_hold_cnt  <= '0;
      r_animation <= 1'b0;
      r_counter   <= 4'd0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_vsync_q   <= vsync;
      r_frame_cnt <= w_frame_cnt_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_animation <= w_animation_next;
      r_counter   <= w_counter_next;
      r_done      <= w_done_next;
    end
  end

  // Next-state and next-output logic. Outputs are computed alongside the
  // state so they can be registered with it; nothing reaches the ports
  // combinationally.
  always_comb begin
    w_state_next     = r_state;
    w_frame_cnt_next = r_frame_cnt;
    w_hold_cnt_next  = r_hold_cnt;
    w_animation_next = r_animation;
    w_counter_next   = r_counter;
    w_done_next      = r_done;

    if (!start_game) begin
      // Dropping start_game aborts from any state, including HOLD and DONE.
      w_state_next     = S_IDLE;
      w_frame_cnt_next = '0;
      w_hold_cnt_next  = '0;
      w_animation_next = 1'b0;
      w_counter_next   = 4'd0;
      w_done_next      = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // skip is meaningless before a run has started.
          w_state_next     = S_RUN;
          w_frame_cnt_next = '0;
          w_hold_cnt_next  = '0;
          w_animation_next = 1'b1;
          w_counter_next   = 4'd0;
          w_done_next      = 1'b0;
        end

        S_RUN: begin
          if (skip) begin
            // skip outranks a coincident tick.
            w_state_next     = S_DONE;
            w_animation_next = 1'b0;
            w_counter_next   = STEP_MAX;
            w_done_next      = 1'b1;
          end else if (w_tick) begin
            if (r_frame_cnt == FRAME_LAST) begin
              w_frame_cnt_next = '0;
              w_counter_next   = r_counter + 4'd1;
              if (r_counter == STEP_LAST) begin
                w_state_next    = S_HOLD;
                w_hold_cnt_next = '0;
                w_done_next     = 1'b1;
              end
            end else begin
              w_frame_cnt_next = r_frame_cnt + 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (skip) begin
            w_state_next     = S_DONE;
            w_animation_next = 1'b0;
            w_counter_next   = STEP_MAX;
            w_done_next      = 1'b1;
          end else if (w_tick) begin
            // The HOLD_FRAMES-th tick ends the hold; hold_cnt parks at
            // HOLD_FRAMES rather than wrapping.
            w_hold_cnt_next = r_hold_cnt + 1'b1;
            if (r_hold_cnt == HOLD_LAST) begin
              w_state_next     = S_DONE;
              w_animation_next = 1'b0;
            end
          end
        end

        S_DONE: begin
          // Parked until start_game drops; a held-high start_game must not
          // re-arm the sequence.
          w_state_next = S_DONE;
        end

        default: begin
          w_state_next     = S_IDLE;
          w_frame_cnt_next = '0;
          w_hold_cnt_next  = '0;
          w_animation_next = 1'b0;
          w_counter_next   = 4'd0;
          w_done_next      = 1'b0;
        end
      endcase
    end
  end

  assign animation = r_animation;
  assign counter   = r_counter;
  assign done      = r_done;

endmodule

// File: tb/tb_animation_ladder_ctl.sv
module tb_animation_ladder_ctl;

  // Instance A: small parameters for the short sequence checks.
  localparam int A_FPS = 2;
  localparam int A_MAX = 3;
  localparam int A_HLD = 2;
  // Instance B: default parameters.
  localparam int B_FPS = 8;
  localparam int B_MAX = 15;
  localparam int B_HLD = 30;

  logic       clk;
  logic       rst;
  logic       start_game;
  logic       vsync;
  logic       skip;
  logic       anim_a, done_a, anim_b, done_b;
  logic [3:0] cnt_a, cnt_b;

  animation_ladder_ctl #(
    .FRAMES_PER_STEP(A_FPS), .MAX_STEP(A_MAX), .HOLD_FRAMES(A_HLD)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start_game(start_game), .vsync(vsync), .skip(skip),
    .animation(anim_a), .counter(cnt_a), .done(done_a)
  );

  animation_ladder_ctl #(
    .FRAMES_PER_STEP(B_FPS), .MAX_STEP(B_MAX), .HOLD_FRAMES(B_HLD)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start_game(start_game), .vsync(vsync), .skip(skip),
    .animation(anim_b), .counter(cnt_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: a run is a count of frame ticks since it began.
  // counter = ticks / FPS until MAX*FPS ticks, then HOLD for HOLD ticks,
  // then DONE. A skip marks the run finished.
  // ---------------------------------------------------------------------
  bit m_active [2];
  bit m_skip   [2];
  int m_ticks  [2];
  bit m_prev_v;

  function automatic int p_fps(int k); return (k == 0) ? A_FPS : B_FPS; endfunction
  function automatic int p_max(int k); return (k == 0) ? A_MAX : B_MAX; endfunction
  function automatic int p_hld(int k); return (k == 0) ? A_HLD : B_HLD; endfunction

  task automatic model_reset();
    m_prev_v = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0;
      m_skip[k]   = 1'b0;
      m_ticks[k]  = 0;
    end
  endtask

  task automatic model_step(input bit rs, input bit sg, input bit vs, input bit sk);
    bit tick;
    if (rs) begin
      model_reset();
      return;
    end
    tick     = vs && !m_prev_v;
    m_prev_v = vs;
    for (int k = 0; k < 2; k++) begin
      if (!sg) begin
        m_active[k] = 1'b0;
      end else if (!m_active[k]) begin
        m_active[k] = 1'b1;
        m_skip[k]   = 1'b0;
        m_ticks[k]  = 0;
      end else if (sk) begin
        m_skip[k] = 1'b1;
      end else if (tick && m_ticks[k] < 10000) begin
        m_ticks[k]++;
      end
    end
  endtask

  // returns {animation, counter, done}
  function automatic logic [5:0] model_out(int k);
    int lim;
    lim = p_max(k) * p_fps(k);
    if (!m_active[k])
      return 6'd0;
    else if (m_skip[k] || m_ticks[k] >= lim + p_hld(k))
      return {1'b0, 4'(p_max(k)), 1'b1};
    else if (m_ticks[k] >= lim)
      return {1'b1, 4'(p_max(k)), 1'b1};
    else
      return {1'b1, 4'(m_ticks[k] / p_fps(k)), 1'b0};
  endfunction

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [5:0] ea, eb;
      ea = model_out(0);
      eb = model_out(1);
      chk("cyc_anim_a", int'(anim_a), int'(ea[5]));
      chk("cyc_cnt_a",  int'(cnt_a),  int'(ea[4:1]));
      chk("cyc_done_a", int'(done_a), int'(ea[0]));
      chk("cyc_anim_b", int'(anim_b), int'(eb[5]));
      chk("cyc_cnt_b",  int'(cnt_b),  int'(eb[4:1]));
      chk("cyc_done_b", int'(done_b), int'(eb[0]));
    end
  end

  // One clock: drive inputs, let the edge happen, advance the model with the
  // values the edge sampled, then move inputs off the edge.
  task automatic cyc(input bit rs, input bit sg, input bit vs, input bit sk);
    rst        = rs;
    start_game = sg;
    vsync      = vs;
    skip       = sk;
    if (rs) model_reset();
    @(posedge clk);
    model_step(rs, sg, vs, sk);
    #1;
  endtask

  task automatic pulse();
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
  endtask

  task automatic lit_a(input string nm, input int an, input int cn, input int dn);
    chk({nm, "_anim"}, int'(anim_a), an);
    chk({nm, "_cnt"},  int'(cnt_a),  cn);
    chk({nm, "_done"}, int'(done_a), dn);
  endtask

  initial begin
    bit sg_r;
    bit vs_r;
    rst = 1'b1; start_game = 1'b0; vsync = 1'b0; skip = 1'b0;
    model_reset();

    // Reset state
    cyc(1, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 0, 0);
    lit_a("reset", 0, 0, 0);
    chk("reset_cnt_b", int'(cnt_b), 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Full sequence on A: 8 pulses
    cyc(0, 1, 0, 0);
    lit_a("start", 1, 0, 0);
    pulse(); pulse();
    lit_a("tick2", 1, 1, 0);
    pulse(); pulse();
    lit_a("tick4", 1, 2, 0);
    pulse(); pulse();
    lit_a("tick6", 1, 3, 1);
    pulse();
    lit_a("tick7", 1, 3, 1);
    pulse();
    lit_a("tick8", 0, 3, 1);

    // No restart while start_game stays high
    for (int i = 0; i < 10; i++) pulse();
    lit_a("norestart", 0, 3, 1);

    // Abort, then fresh run
    cyc(0, 0, 0, 0);
    lit_a("abort", 0, 0, 0);
    cyc(0, 1, 0, 0);
    lit_a("fresh", 1, 0, 0);

    // Abort from HOLD
    for (int i = 0; i < 6; i++) pulse();
    lit_a("hold_pre", 1, 3, 1);
    cyc(0, 0, 0, 0);
    lit_a("hold_abort", 0, 0, 0);
    cyc(0, 1, 0, 0);
    lit_a("hold_fresh", 1, 0, 0);

    // Long vsync: one tick only
    for (int i = 0; i < 100; i++) cyc(0, 1, 1, 0);
    lit_a("longv", 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    pulse();
    lit_a("longv_next", 1, 1, 0);

    // skip coincident with a tick at counter=1
    cyc(0, 1, 1, 1);
    lit_a("skip", 0, 3, 1);
    chk("skip_cnt_b", int'(cnt_b), B_MAX);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 1);
    lit_a("skip_done", 0, 3, 1);

    // Asynchronous reset mid-RUN with B at counter 5
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 40; i++) pulse();
    chk("pre_rst_cnt_b", int'(cnt_b), 5);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_anim_b", int'(anim_b), 0);
    chk("async_rst_cnt_b",  int'(cnt_b),  0);
    chk("async_rst_done_b", int'(done_b), 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("post_rst_idle_b", int'(anim_b), 0);
    cyc(0, 1, 0, 0);
    chk("post_rst_run_b", int'(anim_b), 1);

    // Randomized phase
    sg_r = 1'b1;
    vs_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      bit rs, sk;
      if (sg_r) sg_r = ($urandom_range(0, 399) != 0);
      else      sg_r = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) vs_r = ~vs_r;
      sk = ($urandom_range(0, 299) == 0);
      rs = ($urandom_range(0, 1499) == 0);
      cyc(rs, sg_r, vs_r, sk);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
